dmem_ctrl: RTL
==============

# dmem_ctrl

MEM-stage data-memory controller: the producer on the write side of the MEM/WB pipeline register. It takes load/store requests from the EX/MEM register and runs a req/ack handshake to the off-chip data memory. It returns load data to MEM/WB's memory-read-data input and drives `stall_o`, which freezes the pipeline and deasserts the MEM/WB enable while an access is outstanding. An optional one-entry store buffer lets stores retire without stalling.

## Interface
Parameters:
- `DATA_W`, 32, data and address width.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `MemRead_i`  in  1  load request from EX/MEM.
- `MemWrite_i`  in  1  store request from EX/MEM.
- `addr_i`  in  DATA_W  byte address; ALU result from EX/MEM.
- `wdata_i`  in  DATA_W  store data.
- `rdata_o`  out  DATA_W  load data, connected to the MEM/WB memory-read-data input.
- `stall_o`  out  1  pipeline hold; MEM/WB enable is `!stall_o`.
- `mem_req_o`  out  1  memory request; held until acknowledged.
- `mem_we_o`  out  1  1 = write, 0 = read; valid while `mem_req_o` is high.
- `mem_addr_o`  out  DATA_W  word address, equal to `{addr[31:2], 2'b00}`.
- `mem_wdata_o`  out  DATA_W  write data.
- `mem_ack_i`  in  1  one-cycle completion pulse.
- `mem_rdata_i`  in  DATA_W  read data; valid in the `mem_ack_i` cycle.

## Operation
- The FSM has three states: S_IDLE, S_BUSY and S_DONE.
- **S_IDLE**
  - On an access (`MemRead_i | MemWrite_i`): latch address, write data and direction into request registers, then go to S_BUSY.
  - `stall_o` = 1 combinationally in this same cycle.
- **S_BUSY**
  - `mem_req_o` = 1 with stable address, data and direction.
  - When `mem_ack_i` = 1: for a read, capture `mem_rdata_i` into `rdata_o`; drop `mem_req_o` on the next edge; go to S_DONE.
  - `stall_o` = 1.
- **S_DONE**
  - `stall_o` = 0, so the pipeline advances and MEM/WB captures `rdata_o` at the closing edge.
  - The held EX/MEM request is still on the inputs; it is not re-issued.
  - Go to S_IDLE.
- **No access**: `stall_o` = 0 and the FSM stays in S_IDLE.
- **Read and write both high**: illegal; treated as a read and no write is issued.
- **`rdata_o` hold**: holds its last loaded value. It updates only on a read acknowledge.
- **Unexpected ack**: `mem_ack_i` outside S_BUSY, or outside buffer drain, is ignored.
- **Reset mid-access**
  - FSM returns to S_IDLE and `mem_req_o` drops.
  - A late ack is ignored.
- **`stall_o` during reset**: forced to 0 while `rst_i` = 1.
- **Reset values**: `rdata_o` = 0, `stall_o` = 0, `mem_req_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0.

## Timing
- **Stall window**: `stall_o` is asserted from the cycle a load or store is first seen through the ack cycle.
- **`mem_req_o` timing**: registered; it first rises one cycle after the access is seen.
- **Minimum latency**: ack in the first request cycle gives 2 stall cycles; S_DONE is cycle 2.
- **General latency**: ack arriving N cycles after `mem_req_o` rises gives N+2 stall cycles.
- **Handshake**: the memory sees `mem_req_o` continuously high until the ack cycle, then low for at least one cycle. No back-to-back requests are issued without an intervening S_DONE/S_IDLE.

## Configuration
- Macro: `DMEM_STORE_BUF_EN`.
- **Without the macro**: stores follow the full FSM and stall like loads.
- **With the macro: store, buffer empty**
  - In S_IDLE, a store with the buffer empty loads address and data into the buffer with zero stall.
  - The buffer drains with `mem_we_o` = 1 on the next cycle onward and clears on ack.
- **With the macro: access while buffer full**
  - A load or store seen while the buffer is full stalls until the drain ack.
  - That access is then processed normally in the following cycle; a store enters the buffer, a load starts S_BUSY.
  - Loads never bypass the buffer, so no address compare is needed.
- **With the macro: reset**: reset empties the buffer and discards the pending write.

## Structure
- **Shared package `dmem_pkg`**:
  - state enum S_IDLE, S_BUSY, S_DONE;
  - word-align mask constant;
  - `DATA_W` default.
- **Sub-module `dmem_store_buf`** (only under the macro):
  - one entry: valid, addr, data;
  - load, drain-ack and clear controls.

## Test plan
- **Single load**:
  - Stimulus: load at 0x0000_0104, memory acks in the first request cycle with 0xDEAD_BEEF.
  - Response: `stall_o` high for 2 cycles; `mem_addr_o` = 0x0000_0104; `rdata_o` = 0xDEAD_BEEF in S_DONE; exactly one request.
- **Slow ack**:
  - Stimulus: load with ack 5 cycles after `mem_req_o` rises.
  - Response: 7 stall cycles; `mem_req_o` stable the whole time; no second request while the held input persists in S_DONE.
- **Store, macro off**:
  - Stimulus: store 0x1234_5678 to 0x0000_0203.
  - Response: `mem_addr_o` = 0x0000_0200; `mem_we_o` = 1; 2 stall cycles; `rdata_o` unchanged.
- **Store then load, macro on**:
  - Stimulus: store 0xA5A5_A5A5 to 0x10, then a load from 0x10 the next cycle; memory ack latency 3.
  - Response: the store causes 0 stall cycles; the load stalls until the store drain ack, then performs its own read.
- **Reset mid-access**:
  - Stimulus: `rst_i` in the second S_BUSY cycle, then an ack one cycle later.
  - Response: all outputs return to reset values; the ack is ignored; the next load behaves as in the single-load case.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
// Used by dmem_ctrl and, when DMEM_STORE_BUF_EN is defined, dmem_store_buf.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;

    // Byte-offset bits cleared to form the word address sent to memory.
    localparam logic [1:0] DMEM_BYTE_OFS_MASK = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_store_buf.sv
// One-entry posted-write buffer; a loaded store is drained to memory until acked.
// Only present when DMEM_STORE_BUF_EN is defined.
`ifdef DMEM_STORE_BUF_EN
module dmem_store_buf
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Ack wins over load: the controller never loads a full buffer anyway.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_ack) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule
`endif

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: req/ack handshake to off-chip memory, pipeline stall.
// Define DMEM_STORE_BUF_EN to let stores retire through a one-entry buffer without stalling.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [DATA_W-1:0] LP_ALIGN_MASK = ~DATA_W'(DMEM_BYTE_OFS_MASK);

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_access;
    logic              w_is_store;
    logic              w_start;
    logic              w_wait;
    logic [DATA_W-1:0] w_word_addr;

    // Read wins when both strobes are high, so a store is only a pure write.
    assign w_access    = MemRead_i | MemWrite_i;
    assign w_is_store  = MemWrite_i & ~MemRead_i;
    assign w_word_addr = addr_i & LP_ALIGN_MASK;

`ifdef DMEM_STORE_BUF_EN
    logic              w_buf_valid;
    logic              w_buf_load;
    logic              w_buf_ack;
    logic [DATA_W-1:0] w_buf_addr;
    logic [DATA_W-1:0] w_buf_data;

    // Any access waits behind a pending write; loads never bypass it.
    assign w_wait     = (r_state == S_IDLE) && w_access && w_buf_valid;
    assign w_buf_load = (r_state == S_IDLE) && w_is_store && !w_buf_valid;
    assign w_start    = (r_state == S_IDLE) && w_access && !w_is_store && !w_buf_valid;
    assign w_buf_ack  = mem_ack_i && w_buf_valid;

    dmem_store_buf #(
        .DATA_W (DATA_W)
    ) u_store_buf (
        .i_clk   (clk_i),
        .i_clr   (rst_i),
        .i_load  (w_buf_load),
        .i_ack   (w_buf_ack),
        .i_addr  (w_word_addr),
        .i_data  (wdata_i),
        .o_valid (w_buf_valid),
        .o_addr  (w_buf_addr),
        .o_data  (w_buf_data)
    );

    // Buffer drain and FSM request are never active together.
    assign mem_req_o   = r_req | w_buf_valid;
    assign mem_we_o    = w_buf_valid ? 1'b1       : r_we;
    assign mem_addr_o  = w_buf_valid ? w_buf_addr : r_addr;
    assign mem_wdata_o = w_buf_valid ? w_buf_data : r_wdata;
`else
    assign w_wait  = 1'b0;
    assign w_start = (r_state == S_IDLE) && w_access;

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= w_word_addr;
                        r_wdata <= wdata_i;
                        r_we    <= w_is_store;
                        r_req   <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ack_i) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                        r_state <= S_DONE;
                    end
                end
                // The EX/MEM request is still held here; it is not re-issued.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_o = !rst_i && ((r_state == S_BUSY) || w_start || w_wait);
    assign rdata_o = r_rdata;

endmodule
